// File: rtl/gpio_ctrl.sv
// Memory-mapped GPIO controller: direction, output latch with set/clear,
// synchronised inputs and edge-detect interrupts with W1C status.
module gpio_ctrl #(
  parameter int GPIO_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            addr,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  input  logic [GPIO_WIDTH-1:0] gpio_in,
  output logic [GPIO_WIDTH-1:0] gpio_out,
  output logic [GPIO_WIDTH-1:0] gpio_oe,
  output logic                  irq
);

  localparam int GW = GPIO_WIDTH;
  localparam int CW = $clog2(SYNC_STAGES + 2);
  localparam logic [CW-1:0] PRIME_MAX = CW'(SYNC_STAGES + 1);

  localparam logic [2:0] A_DIN  = 3'd0;
  localparam logic [2:0] A_DOUT = 3'd1;
  localparam logic [2:0] A_DIR  = 3'd2;
  localparam logic [2:0] A_IEN  = 3'd3;
  localparam logic [2:0] A_ESEL = 3'd4;
  localparam logic [2:0] A_STAT = 3'd5;
  localparam logic [2:0] A_SET  = 3'd6;
  localparam logic [2:0] A_CLR  = 3'd7;

  logic [GW-1:0] sync_q [SYNC_STAGES];
  logic [GW-1:0] wval;
  logic [GW-1:0] din;
  logic [GW-1:0] prev;
  logic [GW-1:0] data_out;
  logic [GW-1:0] dir;
  logic [GW-1:0] irq_en;
  logic [GW-1:0] edge_sel;
  logic [GW-1:0] irq_stat;
  logic [GW-1:0] rise;
  logic [GW-1:0] fall;
  logic [GW-1:0] hit;
  logic [GW-1:0] w1c;
  logic [GW-1:0] rd_val;
  logic [CW-1:0] prime;
  logic          primed;

  assign wval = wdata[GW-1:0];
  assign din  = sync_q[SYNC_STAGES-1];

  if (DATA_WIDTH > GW) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^wdata[DATA_WIDTH-1:GW];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++)
        sync_q[i] <= '0;
      prev <= '0;
    end else begin
      sync_q[0] <= gpio_in;
      for (int i = 1; i < SYNC_STAGES; i++)
        sync_q[i] <= sync_q[i-1];
      prev <= din;
    end
  end

  // Edges stay masked until the synchroniser and prev hold real pin data
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      prime <= '0;
    else if (!primed)
      prime <= prime + CW'(1);
  end

  assign primed = (prime == PRIME_MAX);
  assign rise   = din & ~prev;
  assign fall   = ~din & prev;
  assign hit    = primed ? ((rise & ~edge_sel) | (fall & edge_sel)) : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out <= '0;
      dir      <= '0;
      irq_en   <= '0;
      edge_sel <= '0;
    end else if (wr_en) begin
      unique case (addr)
        A_DOUT:  data_out <= wval;
        A_DIR:   dir      <= wval;
        A_IEN:   irq_en   <= wval;
        A_ESEL:  edge_sel <= wval;
        A_SET:   data_out <= data_out | wval;
        A_CLR:   data_out <= data_out & ~wval;
        default: ;
      endcase
    end
  end

  // A new edge in the same cycle as a W1C keeps the bit set
  assign w1c = (wr_en && addr == A_STAT) ? wval : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      irq_stat <= '0;
    else
      irq_stat <= (irq_stat & ~w1c) | hit;
  end

  assign gpio_out = data_out & dir;
  assign gpio_oe  = dir;
  assign irq      = |(irq_stat & irq_en);

  always_comb begin
    rd_val = '0;
    if (rd_en) begin
      unique case (addr)
        A_DIN:   rd_val = din;
        A_DOUT:  rd_val = data_out;
        A_DIR:   rd_val = dir;
        A_IEN:   rd_val = irq_en;
        A_ESEL:  rd_val = edge_sel;
        A_STAT:  rd_val = irq_stat;
        default: rd_val = '0;
      endcase
    end
    rdata = '0;
    rdata[GW-1:0] = rd_val;
  end

endmodule
